// File: rtl/contador_pkg.sv
// Shared types for the up/down sweep counter: operating modes and dwell counter width.
package contador_pkg;

  typedef enum logic [1:0] {
    BOUNCE    = 2'b00,
    UP_WRAP   = 2'b01,
    DOWN_WRAP = 2'b10,
    FREEZE    = 2'b11
  } mode_e;

  localparam int DWELL_W = 8;

endpackage

// File: rtl/contador_dwell.sv
// Loadable down-counter that holds the sweep at an endpoint; busy doubles as HOLD.
module contador_dwell
  import contador_pkg::*;
(
  input  logic               CLK,
  input  logic               r,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               busy
);

  logic [DWELL_W-1:0] cnt;

  // A fresh arrival wins over a clear issued on the same edge (e.g. mode change that lands on an endpoint).
  always_ff @(posedge CLK) begin
    if (r) begin
      cnt <= '0;
    end else if (en) begin
      if (load) begin
        cnt <= load_val;
      end else if (clr) begin
        cnt <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/contador_vaivem.sv
// Up/down sweep counter with run-time bounds, bounce/wrap/freeze modes and endpoint dwell.
module contador_vaivem
  import contador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DWELL = 1
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] LO,
  input  logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] O,
  output logic             DIR,
  output logic             EDGE,
  output logic             HOLD
);

  localparam logic [DWELL_W-1:0] DWELL_V = DWELL_W'(DWELL);

  mode_e            mode_in;
  mode_e            mode_q;
  logic             mode_chg;
  logic             degen;
  logic             out_rng;
  logic             dwelling;
  logic             bnc_up;
  logic [WIDTH-1:0] o_inc;
  logic [WIDTH-1:0] o_dec;

  logic [WIDTH-1:0] o_nxt;
  logic             dir_nxt;
  logic             edge_nxt;
  logic             dw_load;
  logic             dw_clr;

  assign mode_in  = mode_e'(MODE);
  assign mode_chg = (mode_in != mode_q);
  assign degen    = (LO >= HI);
  assign out_rng  = (O < LO) || (O > HI);
  assign dwelling = HOLD && !mode_chg;
  assign o_inc    = O + 1'b1;
  assign o_dec    = O - 1'b1;

  // In bounce, a value parked on the far endpoint (e.g. after a mode switch) turns around instead of overrunning.
  assign bnc_up = DIR ? (O == LO) : (O != HI);

  always_comb begin
    o_nxt    = O;
    dir_nxt  = DIR;
    edge_nxt = 1'b0;
    dw_load  = 1'b0;
    dw_clr   = 1'b0;
    if (degen) begin
      o_nxt   = LO;
      dir_nxt = 1'b0;
      dw_clr  = 1'b1;
    end else if (mode_in == FREEZE) begin
      dw_clr = 1'b1;
    end else if (out_rng) begin
      dw_clr = 1'b1;
      if (mode_in == DOWN_WRAP) begin
        o_nxt   = HI;
        dir_nxt = 1'b1;
      end else begin
        o_nxt   = LO;
        dir_nxt = 1'b0;
      end
    end else if (!dwelling) begin
      dw_clr = mode_chg;
      case (mode_in)
        BOUNCE: begin
          if (bnc_up) begin
            o_nxt    = o_inc;
            dir_nxt  = (o_inc == HI);
            edge_nxt = (o_inc == HI);
          end else begin
            o_nxt    = o_dec;
            dir_nxt  = (o_dec != LO);
            edge_nxt = (o_dec == LO);
          end
        end
        UP_WRAP: begin
          dir_nxt = 1'b0;
          if (O == HI) begin
            o_nxt = LO;
          end else begin
            o_nxt    = o_inc;
            edge_nxt = (o_inc == HI);
          end
        end
        DOWN_WRAP: begin
          dir_nxt = 1'b1;
          if (O == LO) begin
            o_nxt = HI;
          end else begin
            o_nxt    = o_dec;
            edge_nxt = (o_dec == LO);
          end
        end
        default: begin
        end
      endcase
      dw_load = edge_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      O      <= '0;
      DIR    <= 1'b0;
      EDGE   <= 1'b0;
      mode_q <= BOUNCE;
    end else if (EN) begin
      O      <= o_nxt;
      DIR    <= dir_nxt;
      EDGE   <= edge_nxt;
      mode_q <= mode_in;
    end else begin
      EDGE <= 1'b0;
    end
  end

  contador_dwell u_dwell (
    .CLK      (CLK),
    .r        (R),
    .en       (EN),
    .clr      (dw_clr),
    .load     (dw_load),
    .load_val (DWELL_V),
    .busy     (HOLD)
  );

endmodule

// File: tb/tb_contador_vaivem.sv
// Scoreboard bench: three counter instances driven by directed and random stimulus against a reference model.
module tb_contador_vaivem;
  import contador_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rr [3];
  logic       en [3];
  logic [1:0] md [3];
  logic [7:0] lo [3];
  logic [7:0] hi [3];

  logic [3:0] o0;
  logic [7:0] o1, o2;
  logic       dir0, dir1, dir2, edg0, edg1, edg2, hold0, hold1, hold2;

  contador_vaivem #(.WIDTH(4), .DWELL(1)) u0 (
    .CLK(CLK), .R(rr[0]), .EN(en[0]), .MODE(md[0]), .LO(lo[0][3:0]), .HI(hi[0][3:0]),
    .O(o0), .DIR(dir0), .EDGE(edg0), .HOLD(hold0));
  contador_vaivem #(.WIDTH(8), .DWELL(3)) u1 (
    .CLK(CLK), .R(rr[1]), .EN(en[1]), .MODE(md[1]), .LO(lo[1]), .HI(hi[1]),
    .O(o1), .DIR(dir1), .EDGE(edg1), .HOLD(hold1));
  contador_vaivem #(.WIDTH(8), .DWELL(0)) u2 (
    .CLK(CLK), .R(rr[2]), .EN(en[2]), .MODE(md[2]), .LO(lo[2]), .HI(hi[2]),
    .O(o2), .DIR(dir2), .EDGE(edg2), .HOLD(hold2));

  typedef struct packed {
    logic [7:0] o;
    logic       d;
    logic       e;
    logic       h;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int checks = 0;
  int errors = 0;

  // Reference state: value, direction, remaining dwell, last applied mode, edge pulse.
  int m_o [3], m_dir [3], m_dw [3], m_md [3], m_e [3];

  task automatic model_step(input int i);
    int mx, dwl, mode, l, h, up;
    bit chg;
    mx  = (i == 0) ? 15 : 255;
    dwl = (i == 0) ? 1 : (i == 1) ? 3 : 0;
    if (rr[i]) begin
      m_o[i] = 0; m_dir[i] = 0; m_dw[i] = 0; m_md[i] = 0; m_e[i] = 0;
    end else if (!en[i]) begin
      m_e[i] = 0;
    end else begin
      mode = int'(md[i]);
      l = int'(lo[i]) & mx;
      h = int'(hi[i]) & mx;
      chg = (mode != m_md[i]);
      m_md[i] = mode;
      m_e[i] = 0;
      if (l >= h) begin
        m_o[i] = l; m_dir[i] = 0; m_dw[i] = 0;
      end else if (mode == 3) begin
        m_dw[i] = 0;
      end else if (m_o[i] < l || m_o[i] > h) begin
        m_o[i] = (mode == 2) ? h : l;
        m_dir[i] = (mode == 2) ? 1 : 0;
        m_dw[i] = 0;
      end else if (m_dw[i] > 0 && !chg) begin
        m_dw[i] = m_dw[i] - 1;
      end else begin
        m_dw[i] = 0;
        if (mode == 0) begin
          if (m_dir[i] == 0 && m_o[i] == h) m_dir[i] = 1;
          else if (m_dir[i] == 1 && m_o[i] == l) m_dir[i] = 0;
          up = (m_dir[i] == 0) ? 1 : 0;
          m_o[i] = up ? m_o[i] + 1 : m_o[i] - 1;
          if (m_o[i] == (up ? h : l)) begin
            m_e[i] = 1; m_dir[i] = up; m_dw[i] = dwl;
          end
        end else if (mode == 1) begin
          m_dir[i] = 0;
          if (m_o[i] == h) m_o[i] = l;
          else begin
            m_o[i] = m_o[i] + 1;
            if (m_o[i] == h) begin m_e[i] = 1; m_dw[i] = dwl; end
          end
        end else begin
          m_dir[i] = 1;
          if (m_o[i] == l) m_o[i] = h;
          else begin
            m_o[i] = m_o[i] - 1;
            if (m_o[i] == l) begin m_e[i] = 1; m_dw[i] = dwl; end
          end
        end
      end
    end
  endtask

  task automatic push(input int i);
    exp_t x;
    x.o = 8'(m_o[i]);
    x.d = 1'(m_dir[i]);
    x.e = 1'(m_e[i]);
    x.h = (m_dw[i] != 0);
    if (i == 0) q0.push_back(x);
    else if (i == 1) q1.push_back(x);
    else q2.push_back(x);
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      push(i);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input int i, input exp_t exp_v, input exp_t got);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL u%0d outputs @%0t: got O=%0d DIR=%b EDGE=%b HOLD=%b, expected O=%0d DIR=%b EDGE=%b HOLD=%b",
               i, $time, got.o, got.d, got.e, got.h, exp_v.o, exp_v.d, exp_v.e, exp_v.h);
    end
  endtask

  exp_t mon_x;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (q0.size() > 0) begin mon_x = q0.pop_front(); check(0, mon_x, {4'h0, o0, dir0, edg0, hold0}); end
      if (q1.size() > 0) begin mon_x = q1.pop_front(); check(1, mon_x, {o1, dir1, edg1, hold1}); end
      if (q2.size() > 0) begin mon_x = q2.pop_front(); check(2, mon_x, {o2, dir2, edg2, hold2}); end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  int mx, l, h, sel;
  initial begin
    for (int i = 0; i < 3; i++) begin
      rr[i] = 1'b1; en[i] = 1'b1;
      m_o[i] = 0; m_dir[i] = 0; m_dw[i] = 0; m_md[i] = 0; m_e[i] = 0;
    end
    md[0] = BOUNCE;    lo[0] = 8'd0;  hi[0] = 8'd15;
    md[1] = UP_WRAP;   lo[1] = 8'd10; hi[1] = 8'd13;
    md[2] = DOWN_WRAP; lo[2] = 8'd2;  hi[2] = 8'd5;
    tick();
    tick();
    for (int i = 0; i < 3; i++) rr[i] = 1'b0;
    for (int k = 0; k < 40; k++) tick();

    // Pause u1 in the middle of a dwell, then reset it.
    for (int k = 0; k < 20 && m_e[1] != 1; k++) tick();
    tick();
    en[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    en[1] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rr[1] = 1'b1;
    tick();
    rr[1] = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // u0: switch from falling bounce at 7 to wrap-up, then shrink HI below the value.
    for (int k = 0; k < 60 && !(m_o[0] == 7 && m_dir[0] == 1 && m_dw[0] == 0); k++) tick();
    md[0] = UP_WRAP;
    tick();
    tick();
    for (int k = 0; k < 40 && m_o[0] != 7; k++) tick();
    hi[0] = 8'd5;
    tick();
    tick();
    hi[0] = 8'd15;

    // u2: degenerate bounds; u0: freeze with random enable.
    lo[2] = 8'd9; hi[2] = 8'd9;
    for (int k = 0; k < 20; k++) tick();
    lo[2] = 8'd6; hi[2] = 8'd3;
    for (int k = 0; k < 6; k++) tick();
    lo[2] = 8'd2; hi[2] = 8'd5;
    md[0] = FREEZE;
    for (int k = 0; k < 10; k++) begin
      en[0] = 1'($urandom_range(0, 1));
      tick();
    end
    en[0] = 1'b1;
    md[0] = BOUNCE;
    for (int k = 0; k < 5; k++) tick();

    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 3; i++) begin
        mx = (i == 0) ? 15 : 255;
        rr[i] = ($urandom_range(0, 99) == 0);
        en[i] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) md[i] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 29) == 0) begin
          sel = $urandom_range(0, 7);
          l = $urandom_range(0, mx - 1);
          h = l + $urandom_range(1, 6);
          if (h > mx) h = mx;
          if (sel == 0) h = $urandom_range(0, l);
          if (sel == 1) begin l = 0; h = mx; end
          lo[i] = 8'(l);
          hi[i] = 8'(h);
        end
      end
      tick();
    end

    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d expectations left, expected 0", q0.size() + q1.size() + q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_vaivem.md
# contador_vaivem

Parametrised up/down sweep counter with a WIDTH-bit output, run-time bounds LO/HI, a selectable mode (bounce, wrap-up, wrap-down, freeze) and a programmable dwell at endpoints. It is the generalised successor of the team's 4-bit bounce counter. It drives display/LED sweep patterns and test-pattern sequencers in the same exercise set.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (2..16)
- DWELL, 1, extra enabled cycles O holds at an endpoint after arrival (0..255)

Ports:
- CLK  in  1  clock, rising edge
- R  in  1  reset; one clock, reset is synchronous and active-high
- EN  in  1  count enable; low freezes all state
- MODE  in  2  00 BOUNCE, 01 UP_WRAP, 10 DOWN_WRAP, 11 FREEZE
- LO  in  WIDTH  lower bound, inclusive
- HI  in  WIDTH  upper bound, inclusive
- O  out  WIDTH  count value, registered
- DIR  out  1  0 up, 1 down, registered
- EDGE  out  1  one-cycle pulse: O has just arrived at an endpoint
- HOLD  out  1  O is dwelling; the next enabled edge does not move O

## Operation
- Reset (R=1 at an edge, dominates EN): O=0, DIR=0, EDGE=0, HOLD=0, dwell count=0.
- EN=0: O, DIR, dwell count held; EDGE forced 0; HOLD holds its value.
- Degenerate bounds (LO>=HI): O loaded to LO and held, DIR=0, EDGE=0, HOLD=0.
- Out of range (O<LO or O>HI, e.g. after reset or a bound change), enabled edge:
  - O loads LO in BOUNCE and UP_WRAP, HI in DOWN_WRAP.
  - DIR set to the mode direction; no EDGE, no dwell.
- BOUNCE: O steps +1 (DIR=0) or -1 (DIR=1) per enabled edge.
  - Step landing on HI (up) or LO (down) is an arrival: EDGE=1, DIR toggles on the same edge, dwell count loads DWELL.
  - Start-up at LO by reset or load is not an arrival.
- UP_WRAP: DIR=0; step +1.
  - Landing on HI is an arrival, with dwell.
  - The step after the dwell takes O from HI to LO; no EDGE on LO.
- DOWN_WRAP: mirror of UP_WRAP. DIR=1; arrival at LO; after the dwell, LO goes to HI.
- FREEZE: O, DIR held; dwell count cleared; EDGE=0.
- Dwell: while the count is nonzero, an enabled edge decrements it and O stays. HOLD = (count != 0).
- Mode change: applies at the next enabled edge.
  - Dwell count cleared.
  - DIR forced to 0/1 when entering UP_WRAP/DOWN_WRAP; BOUNCE keeps the current DIR.
- Arithmetic: WIDTH-bit unsigned. Stepping never exceeds [LO,HI], so there is no natural overflow. Width-2^WIDTH wrap occurs only when LO=0, HI=2^WIDTH-1 in a wrap mode.

## Timing
- All outputs registered; O changes on the first enabled edge after inputs are sampled (latency 1).
- In an arrival cycle, O=endpoint and EDGE=1 for exactly one cycle. HOLD=1 from that cycle when DWELL>0.
- Endpoint visible for DWELL+1 enabled cycles. DWELL=0: HI is followed by HI-1 (BOUNCE) or LO (UP_WRAP) on the next edge.
- Example, DWELL=1, LO=0, HI=15, BOUNCE, EN=1: O sequence from reset is 0,1..15,15,14..0,0,1… with EDGE on the first 15 and the first 0.
- EN dropped during a dwell: the dwell resumes where it stopped; HOLD stays 1.
- R asserted mid-dwell: O=0 and HOLD=0 after that edge.

## Structure
- Package contador_pkg:
  - typedef enum logic[1:0] mode_e {BOUNCE, UP_WRAP, DOWN_WRAP, FREEZE}
  - localparam DWELL_W = 8
- Sub-module contador_dwell: loadable down-counter with EN, clear and busy flag. It provides the dwell count and HOLD.
- Top module: next-state logic for O/DIR (range check, step, arrival detect, wrap) plus the EDGE register.

## Test plan
- WIDTH=4, DWELL=1, LO=0, HI=15, BOUNCE, EN=1 for 40 cycles -> O = 0..15,15,14..0,0,1..; EDGE high exactly at the two arrivals; DIR toggles on them.
- WIDTH=8, DWELL=3, LO=10, HI=13, UP_WRAP from reset -> O = 10 (load, no EDGE), 11, 12, 13 (EDGE, HOLD), 13, 13, 13, 10, 11…
- DOWN_WRAP, DWELL=0, LO=2, HI=5 -> O = 5 (load), 4, 3, 2 (EDGE), 5, 4…; HOLD never set.
- Mid-dwell: toggle EN low 4 cycles -> O frozen, HOLD=1, EDGE=0; the remaining dwell completes after EN returns. Then assert R for one edge -> O=0, DIR=0, HOLD=0.
- BOUNCE at O=7, DIR=1, switch to UP_WRAP -> DIR=0, next O=8. HI lowered to 5 while O=7 -> next O=LO, no EDGE.
- LO=9, HI=9 or LO>HI -> O=LO held, EDGE and HOLD stay 0 for 20 cycles. FREEZE -> O unchanged regardless of EN.
